// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the carry-pipelined lookahead adder.
package adder_pkg;

    localparam int GRP_W = 4;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

    // Returns 0 for an illegal WIDTH/SEG_W pairing so the top can refuse to elaborate.
    function automatic int seg_count(input int width, input int seg_w);
        if (seg_w <= 0 || width < seg_w) return 0;
        if ((seg_w % GRP_W) != 0 || (width % seg_w) != 0) return 0;
        return width / seg_w;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit carry-lookahead slice: 4-bit groups with explicit
// in-group lookahead, then a lookahead level across groups.
module cla_segment
    import adder_pkg::*;
#(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] sum_o,
    output logic             grp_p_o,
    output logic             grp_g_o
);

    localparam int NG = SEG_W / GRP_W;

    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] c;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_c;
    logic [NG:0]      gterm;
    logic [NG:0]      gprop;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    for (genvar j = 0; j < NG; j++) begin : g_grp
        localparam int B0 = j * GRP_W;

        assign grp_p[j] = &p[B0 +: GRP_W];
        assign grp_g[j] = g[B0+3]
                        | (p[B0+3] & g[B0+2])
                        | (p[B0+3] & p[B0+2] & g[B0+1])
                        | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);

        assign c[B0]   = grp_c[j];
        assign c[B0+1] = g[B0] | (p[B0] & grp_c[j]);
        assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & grp_c[j]);
        assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                       | (p[B0+2] & p[B0+1] & p[B0] & grp_c[j]);
    end

    // gterm[j]/gprop[j]: generate and propagate of groups [j-1:0], flattened sum-of-products.
    always_comb begin
        // NOTE: every variable gets a default before the loops, so no path infers a latch.
        gterm = '0;
        gprop = '1;
        grp_c = '0;
        for (int j = 0; j <= NG; j++) begin
            for (int m = j - 1; m >= 0; m--) begin
                gterm[j] = gterm[j] | (gprop[j] & grp_g[m]);
                gprop[j] = gprop[j] & grp_p[m];
            end
        end
        for (int j = 0; j < NG; j++) begin
            grp_c[j] = gterm[j] | (gprop[j] & cin_i);
        end
    end

    assign sum_o   = p ^ c;
    assign grp_p_o = gprop[NG];
    assign grp_g_o = gterm[NG];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Carry-pipelined WIDTH-bit adder, one SEG_W-bit lookahead segment per stage, valid/ready
// with global stall. Define PIPE_ADD_OVF_EN to add the registered signed-overflow output Ovf.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NUM_SEG = seg_count(WIDTH, SEG_W);
    localparam int LAST    = NUM_SEG - 1;

    if (NUM_SEG == 0) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a multiple of SEG_W, SEG_W a multiple of 4");
    end

    logic stall;

    // Stage k adds segment k and keeps sum bits [LOW_W-1:0] plus the still-unadded operand bits.
    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        localparam int LOW_W = (k + 1) * SEG_W;
        localparam int REM_W = WIDTH - LOW_W;

        logic [SEG_W-1:0] seg_a;
        logic [SEG_W-1:0] seg_b;
        logic [SEG_W-1:0] seg_sum;
        logic             seg_cin;
        logic             seg_p;
        logic             seg_g;
        logic             valid_in;
        logic [LOW_W-1:0] low_d;
        logic [LOW_W-1:0] low_q;
        stage_ctrl_t      ctrl_d;
        stage_ctrl_t      ctrl_q;

        if (k == 0) begin : g_src
            assign seg_a    = A[SEG_W-1:0];
            assign seg_b    = B[SEG_W-1:0];
            assign seg_cin  = Cin;
            assign valid_in = in_valid;
            assign low_d    = seg_sum;
        end else begin : g_src
            assign seg_a    = g_stage[k-1].g_rem.a_rem_q[SEG_W-1:0];
            assign seg_b    = g_stage[k-1].g_rem.b_rem_q[SEG_W-1:0];
            assign seg_cin  = g_stage[k-1].ctrl_q.carry;
            assign valid_in = g_stage[k-1].ctrl_q.valid;
            assign low_d    = {seg_sum, g_stage[k-1].low_q};
        end

        cla_segment #(
            .SEG_W(SEG_W)
        ) u_seg (
            .a_i    (seg_a),
            .b_i    (seg_b),
            .cin_i  (seg_cin),
            .sum_o  (seg_sum),
            .grp_p_o(seg_p),
            .grp_g_o(seg_g)
        );

        assign ctrl_d.valid = valid_in;
        assign ctrl_d.carry = seg_g | (seg_p & seg_cin);

        always_ff @(posedge Clk) begin
            if (Reset) begin
                // NOTE: data registers are cleared as well, so S/Cout read 0 straight after reset.
                ctrl_q <= '0;
                low_q  <= '0;
            end else if (!stall) begin
                // NOTE: non-blocking, so each stage captures its neighbour's pre-edge value.
                ctrl_q <= ctrl_d;
                low_q  <= low_d;
            end
        end

        if (REM_W > 0) begin : g_rem
            logic [REM_W-1:0] a_rem_d;
            logic [REM_W-1:0] b_rem_d;
            logic [REM_W-1:0] a_rem_q;
            logic [REM_W-1:0] b_rem_q;

            if (k == 0) begin : g_rem_src
                assign a_rem_d = A[WIDTH-1:SEG_W];
                assign b_rem_d = B[WIDTH-1:SEG_W];
            end else begin : g_rem_src
                assign a_rem_d = g_stage[k-1].g_rem.a_rem_q[REM_W+SEG_W-1:SEG_W];
                assign b_rem_d = g_stage[k-1].g_rem.b_rem_q[REM_W+SEG_W-1:SEG_W];
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (!stall) begin
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                end
            end
        end
    end

    assign out_valid = g_stage[LAST].ctrl_q.valid;
    assign S         = g_stage[LAST].low_q;
    assign Cout      = g_stage[LAST].ctrl_q.carry;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

`ifdef PIPE_ADD_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is recovered from the MSB's own sum bit, then XORed with carry out.
    assign ovf_d = g_stage[LAST].seg_a[SEG_W-1] ^ g_stage[LAST].seg_b[SEG_W-1]
                 ^ g_stage[LAST].seg_sum[SEG_W-1] ^ g_stage[LAST].ctrl_d.carry;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`endif

endmodule
